demux_dispatch_ctrl: RTL and testbench

//   Sequencer for the 1x4 demultiplexer datapath. Accepts a word stream on a

---
 rtl/demux_dispatch_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_demux_dispatch_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_dispatch_ctrl.sv
// -----------------------------------------------------------------------------
// demux_dispatch_ctrl
//
// Sequencer for a 1x4 demultiplexer datapath. Words arrive on a valid/ready
// input and are parked on a shared bus (out_data). The controller drives the
// demux select lines and a one-hot per-channel valid. It then waits for the
// addressed channel to signal ready before it releases the word.
//
// The target channel is taken from in_sel (directed mode) or from an internal
// round-robin pointer (round-robin mode). The following support bring-up and
// debug:
//   - per-channel dispatch counters
//   - a sticky stall-timeout flag
//
// Ports
//   clk           in   1          rising-edge clock
//   rst           in   1          synchronous reset, active-high
//   mode          in   1          0 = directed (in_sel), 1 = round-robin
//   in_sel        in   2          target channel in directed mode
//   in_valid      in   1          input word valid
//   in_data       in   DATA_W     input word
//   in_ready      out  1          controller can accept a word this cycle
//   s1            out  1          demux select MSB (target[1])
//   s0            out  1          demux select LSB (target[0])
//   out_data      out  DATA_W     held word, fed to the demux data input
//   out_valid     out  4          one-hot valid, bit i = channel i
//   out_ready     in   4          per-channel ready
//   dispatch_cnt  out  4*CNT_W    channel i count at [i*CNT_W +: CNT_W]
//   busy          out  1          high while a word is held
//   err_stall     out  1          sticky stall-timeout flag
// -----------------------------------------------------------------------------
module demux_dispatch_ctrl #(
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [1:0]           in_sel,
    input  logic                 in_valid,
    input  logic [DATA_W-1:0]    in_data,
    output logic                 in_ready,
    output logic                 s1,
    output logic                 s0,
    output logic [DATA_W-1:0]    out_data,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [4*CNT_W-1:0]   dispatch_cnt,
    output logic                 busy,
    output logic                 err_stall
);

    // FSM encoding
    localparam logic [0:0] ST_IDLE = 1'b0;   // no word held
    localparam logic [0:0] ST_HOLD = 1'b1;   // word on the bus, awaiting ready

    // The stall counter must be wide enough to hold TIMEOUT itself.
    localparam int                 STALL_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT);

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    logic [0:0]          state_reg,     state_next;
    logic [1:0]          tgt_reg,       tgt_next;
    logic                tgt_rr_reg,    tgt_rr_next;
    logic [DATA_W-1:0]   data_reg,      data_next;
    logic [1:0]          rr_ptr_reg,    rr_ptr_next;
    logic [STALL_W-1:0]  stall_cnt_reg, stall_cnt_next;
    logic                err_stall_reg, err_stall_next;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    logic hold;
    logic tgt_ready;
    logic xfer;
    logic accept;
    logic [1:0] new_tgt;

    assign hold      = (state_reg == ST_HOLD);
    // Only the addressed channel's ready matters. The other bits are ignored.
    assign tgt_ready = out_ready[tgt_reg];
    assign xfer      = hold && tgt_ready;
    // A word can be taken when the bus is empty or when it is emptying on
    // this edge. The second case gives 1 word/cycle throughput.
    assign in_ready  = !rst && (!hold || tgt_ready);
    assign accept    = in_valid && in_ready;

    // The round-robin pointer moves only when a round-robin word completes.
    // Directed words leave the pointer alone. A back-to-back round-robin
    // accept sees the already-advanced pointer, so consecutive RR words walk
    // 0,1,2,3,0,...
    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (xfer && tgt_rr_reg) begin
            rr_ptr_next = tgt_reg + 2'd1;
        end
    end

    assign new_tgt = mode ? rr_ptr_next : in_sel;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        tgt_next    = tgt_reg;
        tgt_rr_next = tgt_rr_reg;
        data_next   = data_reg;

        if (accept) begin
            // A fresh word always wins, even when the previous one is
            // completing on this same edge.
            state_next  = ST_HOLD;
            tgt_next    = new_tgt;
            tgt_rr_next = mode;
            data_next   = in_data;
        end else if (xfer) begin
            // The bus and select lines keep their last value. Only the valid
            // drops, and it is derived from state.
            state_next = ST_IDLE;
        end
    end

    // Stall supervision: count HOLD cycles in which the target is not ready,
    // and saturate so the counter can never wrap back under the threshold.
    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (xfer) begin
            stall_cnt_next = '0;
        end else if (hold && (stall_cnt_reg != STALL_MAX)) begin
            stall_cnt_next = stall_cnt_reg + STALL_W'(1);
        end
    end

    // The flag rises on the same edge on which the count reaches TIMEOUT.
    // Once set, it stays set until reset.
    assign err_stall_next = err_stall_reg || (stall_cnt_next == STALL_MAX);

    // -------------------------------------------------------------------------
    // Sequential core
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            tgt_reg       <= 2'd0;
            tgt_rr_reg    <= 1'b0;
            data_reg      <= '0;
            rr_ptr_reg    <= 2'd0;
            stall_cnt_reg <= '0;
            err_stall_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            tgt_reg       <= tgt_next;
            tgt_rr_reg    <= tgt_rr_next;
            data_reg      <= data_next;
            rr_ptr_reg    <= rr_ptr_next;
            stall_cnt_reg <= stall_cnt_next;
            err_stall_reg <= err_stall_next;
        end
    end

    // -------------------------------------------------------------------------
    // Per-channel dispatch counters and one-hot valid
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_reg [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_chan
        // Counters wrap naturally at 2^CNT_W.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_reg[gi] <= '0;
            end else if (xfer && (tgt_reg == 2'(gi))) begin
                cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
            end
        end

        assign dispatch_cnt[gi*CNT_W +: CNT_W] = cnt_reg[gi];

        // Derived from state and target. This keeps the valid zero or
        // one-hot by construction.
        assign out_valid[gi] = hold && (tgt_reg == 2'(gi));
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign s1        = tgt_reg[1];
    assign s0        = tgt_reg[0];
    assign out_data  = data_reg;
    assign busy      = hold;
    assign err_stall = err_stall_reg;

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_demux_dispatch_ctrl
//
// Directed testbench for demux_dispatch_ctrl. Each scenario task drives its
// own stimulus and compares the outputs against hand-computed values.
// Inputs change and outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_demux_dispatch_ctrl;

    logic        clk;
    logic        rst;
    logic        mode;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        s1;
    logic        s0;
    logic [7:0]  out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] dispatch_cnt;
    logic        busy;
    logic        err_stall;

    int errors = 0;
    int checks = 0;

    demux_dispatch_ctrl #(.DATA_W(8), .CNT_W(8), .TIMEOUT(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .in_sel       (in_sel),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .s1           (s1),
        .s0           (s0),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .dispatch_cnt (dispatch_cnt),
        .busy         (busy),
        .err_stall    (err_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] cnt(input int ch);
        return dispatch_cnt[ch*8 +: 8];
    endfunction

    task automatic reset_dut();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 4'h0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h3C;
        mode      = 1'b0;
        in_sel    = 2'd1;
        out_ready = 4'hF;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready got=%b exp=0", in_ready);
        end
        checks++;
        if (out_valid !== 4'b0000) begin
            errors++;
            $display("FAIL reset_out_valid got=%b exp=0000", out_valid);
        end
        checks++;
        if ({s1, s0} !== 2'b00) begin
            errors++;
            $display("FAIL reset_sel got=%b exp=00", {s1, s0});
        end
        checks++;
        if (dispatch_cnt !== 32'h0) begin
            errors++;
            $display("FAIL reset_counts got=%h exp=0", dispatch_cnt);
        end
        checks++;
        if ({busy, err_stall} !== 2'b00) begin
            errors++;
            $display("FAIL reset_busy_err got=%b exp=00", {busy, err_stall});
        end
        $display("test_reset: in_ready=%b out_valid=%b cnt=%h", in_ready, out_valid, dispatch_cnt);
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_directed();
        mode      = 1'b0;
        in_sel    = 2'd2;
        in_data   = 8'hA5;
        out_ready = 4'hF;
        in_valid  = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL dir_in_ready_idle got=%b exp=1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 4'b0100) begin
            errors++;
            $display("FAIL dir_out_valid got=%b exp=0100", out_valid);
        end
        checks++;
        if ({s1, s0} !== 2'b10) begin
            errors++;
            $display("FAIL dir_sel got=%b exp=10", {s1, s0});
        end
        checks++;
        if (out_data !== 8'hA5) begin
            errors++;
            $display("FAIL dir_out_data got=%h exp=a5", out_data);
        end
        $display("test_directed: accept A5 -> out_valid=%b sel=%b data=%h", out_valid, {s1, s0}, out_data);
        tick();
        checks++;
        if (out_valid !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL dir_release got valid=%b busy=%b exp valid=0000 busy=0", out_valid, busy);
        end
        checks++;
        if (cnt(2) !== 8'd1) begin
            errors++;
            $display("FAIL dir_cnt2 got=%0d exp=1", cnt(2));
        end
        checks++;
        if (out_data !== 8'hA5 || {s1, s0} !== 2'b10) begin
            errors++;
            $display("FAIL dir_bus_keep got data=%h sel=%b exp data=a5 sel=10", out_data, {s1, s0});
        end
        $display("test_directed: transfer -> cnt2=%0d", cnt(2));
    endtask

    // ------------------------------------------------------------------
    // The directed word in test_directed must not have moved rr_ptr, so the
    // first round-robin word here goes to channel 0.
    task automatic test_back_to_back();
        logic [3:0] exp_valid [5];
        exp_valid[0] = 4'b0001;
        exp_valid[1] = 4'b0010;
        exp_valid[2] = 4'b0100;
        exp_valid[3] = 4'b1000;
        exp_valid[4] = 4'b0001;
        mode      = 1'b1;
        in_sel    = 2'd3;   // ignored in round-robin mode
        out_ready = 4'hF;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(10 + i);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_in_ready[%0d] got=%b exp=1", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== exp_valid[i] || out_data !== 8'(10 + i)) begin
                errors++;
                $display("FAIL b2b_word[%0d] got valid=%b data=%0d exp valid=%b data=%0d",
                         i, out_valid, out_data, exp_valid[i], 10 + i);
            end
            $display("test_back_to_back: word %0d -> out_valid=%b", 10 + i, out_valid);
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (cnt(0) !== 8'd2 || cnt(1) !== 8'd1 || cnt(2) !== 8'd2 || cnt(3) !== 8'd1) begin
            errors++;
            $display("FAIL b2b_counts got=%0d,%0d,%0d,%0d exp=2,1,2,1", cnt(0), cnt(1), cnt(2), cnt(3));
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_stall();
        reset_dut();
        mode      = 1'b0;
        in_sel    = 2'd1;
        in_data   = 8'h5A;
        out_ready = 4'b1101;   // only the target channel is not ready
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        in_sel   = 2'd3;       // a change while in HOLD must not matter
        mode     = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        checks++;
        if (err_stall !== 1'b0) begin
            errors++;
            $display("FAIL stall_err_early got=%b exp=0 after 14 cycles", err_stall);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_in_ready got=%b exp=0", in_ready);
        end
        tick();
        checks++;
        if (err_stall !== 1'b1) begin
            errors++;
            $display("FAIL stall_err_set got=%b exp=1 after 15 cycles", err_stall);
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (out_valid !== 4'b0010 || out_data !== 8'h5A || {s1, s0} !== 2'b01) begin
            errors++;
            $display("FAIL stall_hold got valid=%b data=%h sel=%b exp valid=0010 data=5a sel=01",
                     out_valid, out_data, {s1, s0});
        end
        $display("test_stall: 20 stalled cycles -> out_valid=%b err_stall=%b", out_valid, err_stall);
        out_ready = 4'hF;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_ready got=%b exp=1", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 4'b0000 || cnt(1) !== 8'd1 || err_stall !== 1'b1) begin
            errors++;
            $display("FAIL stall_release got valid=%b cnt1=%0d err=%b exp valid=0000 cnt1=1 err=1",
                     out_valid, cnt(1), err_stall);
        end
        $display("test_stall: release -> cnt1=%0d err_stall=%b", cnt(1), err_stall);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_in_hold();
        reset_dut();
        mode      = 1'b1;
        out_ready = 4'hF;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        tick();                 // RR word -> ch0
        in_valid  = 1'b0;
        out_ready = 4'h0;
        tick();                 // still held (not ready)
        out_ready = 4'hF;
        tick();                 // transfer, rr_ptr -> 1
        out_ready = 4'h0;
        in_valid  = 1'b1;
        in_data   = 8'h22;
        tick();                 // RR word -> ch1, held
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 4'b0010 || cnt(0) !== 8'd1) begin
            errors++;
            $display("FAIL rsthold_setup got valid=%b cnt0=%0d exp valid=0010 cnt0=1", out_valid, cnt(0));
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 4'b0000 || dispatch_cnt !== 32'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rsthold_clear got valid=%b cnt=%h busy=%b exp valid=0000 cnt=0 busy=0",
                     out_valid, dispatch_cnt, busy);
        end
        out_ready = 4'hF;
        in_valid  = 1'b1;
        in_data   = 8'h33;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 4'b0001) begin
            errors++;
            $display("FAIL rsthold_rr_restart got=%b exp=0001", out_valid);
        end
        $display("test_reset_in_hold: after reset RR word -> out_valid=%b", out_valid);
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_wrap();
        reset_dut();
        mode      = 1'b0;
        in_sel    = 2'd3;
        out_ready = 4'hF;
        in_valid  = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_data = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (cnt(3) !== 8'd255) begin
            errors++;
            $display("FAIL wrap_cnt3_pre got=%0d exp=255", cnt(3));
        end
        tick();
        checks++;
        if (cnt(3) !== 8'd0) begin
            errors++;
            $display("FAIL wrap_cnt3 got=%0d exp=0", cnt(3));
        end
        checks++;
        if (dispatch_cnt[23:0] !== 24'h0 || out_valid !== 4'b0000) begin
            errors++;
            $display("FAIL wrap_others got cnt=%h valid=%b exp cnt=0 valid=0000", dispatch_cnt, out_valid);
        end
        $display("test_wrap: 256 words -> cnt3=%0d", cnt(3));
    endtask

    initial begin
        rst       = 1'b1;
        mode      = 1'b0;
        in_sel    = 2'd0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 4'h0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_in_hold();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
